// File: rtl/dma_copy_ctrl.sv
// Memory-mapped word-copy DMA engine. It borrows the data-memory port only in
// cycles the CPU leaves idle and raises a maskable level interrupt when done.
module dma_copy_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [11:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Intr,
  input  logic        cpu_mem_busy,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t state_q, next_state;

  logic [31:0]      src_q, dst_q;
  logic [LEN_W-1:0] len_q;
  logic             ie_q, done_q, intr_q;
  logic [31:0]      src_cnt, dst_cnt, buf_q;
  logic [LEN_W-1:0] word_cnt;

  logic reg_wr, reg_rd, ctrl_wr, busy, start_req;
  logic done_d, ie_d;
  logic unused_addr_bits;

  assign unused_addr_bits = ^Addr[11:4];

  assign reg_wr    = !CS_N && !WR_N;
  assign reg_rd    = !CS_N && !RD_N;
  assign ctrl_wr   = reg_wr && (Addr[3:0] == 4'hC);
  assign busy      = (state_q == RD) || (state_q == CAP) || (state_q == WR);
  assign start_req = ctrl_wr && DataIn[0] && !busy;
  assign state_dbg = state_q;
  assign Intr      = intr_q;

  // A DONE set from FIN takes priority over a same-cycle write-1-to-clear.
  always_comb begin
    done_d = done_q;
    ie_d   = ie_q;
    if (ctrl_wr) begin
      ie_d = DataIn[1];
      if (DataIn[2]) done_d = 1'b0;
    end
    if (state_q == FIN) done_d = 1'b1;
  end

  // Memory strobes are gated by cpu_mem_busy so the CPU always wins the port.
  always_comb begin
    next_state = state_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    case (state_q)
      IDLE: begin
        if (start_req) next_state = (len_q != '0) ? RD : FIN;
      end
      RD: begin
        if (!cpu_mem_busy) begin
          mem_en     = 1'b1;
          mem_addr   = src_cnt;
          next_state = CAP;
        end
      end
      CAP: next_state = WR;
      WR: begin
        if (!cpu_mem_busy) begin
          mem_en     = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = dst_cnt;
          mem_wdata  = buf_q;
          next_state = (word_cnt == LEN_W'(1)) ? FIN : RD;
        end
      end
      FIN: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      src_q    <= 32'd0;
      dst_q    <= 32'd0;
      len_q    <= '0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      intr_q   <= 1'b0;
      src_cnt  <= 32'd0;
      dst_cnt  <= 32'd0;
      word_cnt <= '0;
      buf_q    <= 32'd0;
    end else begin
      state_q <= next_state;
      done_q  <= done_d;
      ie_q    <= ie_d;
      intr_q  <= done_d & ie_d;

      if (reg_wr && !busy) begin
        case (Addr[3:0])
          4'h0: src_q <= {DataIn[31:2], 2'b00};
          4'h4: dst_q <= {DataIn[31:2], 2'b00};
          4'h8: len_q <= DataIn[LEN_W-1:0];
          default: ;
        endcase
      end

      // Working copies keep the programmed registers intact across a transfer.
      if (state_q == IDLE && start_req && len_q != '0) begin
        src_cnt  <= src_q;
        dst_cnt  <= dst_q;
        word_cnt <= len_q;
      end

      if (state_q == CAP) buf_q <= mem_rdata;

      if (state_q == WR && !cpu_mem_busy) begin
        src_cnt  <= src_cnt + 32'd4;
        dst_cnt  <= dst_cnt + 32'd4;
        word_cnt <= word_cnt - LEN_W'(1);
      end
    end
  end

  always_comb begin
    DataOut = 32'd0;
    if (reg_rd) begin
      case (Addr[3:0])
        4'h0: DataOut = src_q;
        4'h4: DataOut = dst_q;
        4'h8: DataOut = 32'(len_q);
        4'hC: DataOut = {29'd0, done_q, ie_q, busy};
        default: DataOut = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Directed bench for dma_copy_ctrl: register map, copy timing, contention,
// zero length, busy-time writes, address wrap and mid-transfer reset.
module tb_dma_copy_ctrl;

  logic        clk;
  logic        reset;
  logic        CS_N, RD_N, WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Intr;
  logic        cpu_mem_busy;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  state_dbg;

  int checks = 0;
  int fails  = 0;

  // 1024-word memory; byte address bits [11:2] select the word, so 0xFFFFFFFC aliases word 1023.
  logic [31:0] mem [0:1023];
  logic [31:0] rd_addr_q[$];
  int          en_cnt = 0;
  int          busy_viol = 0;
  logic        tb_we;
  logic [9:0]  tb_idx;
  logic [31:0] tb_data;

  dma_copy_ctrl #(.LEN_W(16)) dut (
    .clk(clk), .reset(reset), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
    .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut), .Intr(Intr),
    .cpu_mem_busy(cpu_mem_busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model and port monitor
  always @(posedge clk) begin
    if (tb_we) mem[tb_idx] <= tb_data;
    if (mem_en && mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    if (mem_en && !mem_we) begin
      mem_rdata <= mem[mem_addr[11:2]];
      rd_addr_q.push_back(mem_addr);
    end
    if (mem_en) en_cnt++;
    if (mem_en && cpu_mem_busy) busy_viol++;
  end

  // driver tasks (called just after a rising edge)
  task automatic write_reg(input logic [11:0] a, input logic [31:0] d);
    Addr = a; DataIn = d; CS_N = 1'b0; WR_N = 1'b0;
    @(posedge clk); #1;
    CS_N = 1'b1; WR_N = 1'b1;
  endtask

  task automatic read_reg(input logic [11:0] a, output logic [31:0] d);
    Addr = a; CS_N = 1'b0; RD_N = 1'b0;
    #1 d = DataOut;
    CS_N = 1'b1; RD_N = 1'b1;
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] d);
    tb_we = 1'b1; tb_idx = idx; tb_data = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // Counts edges after the START edge until Intr rises; optional alternate-cycle contention.
  task automatic wait_intr(input bit contend, input int max, output int k);
    k = -1;
    for (int i = 1; i <= max; i++) begin
      cpu_mem_busy = contend ? i[0] : 1'b0;
      @(posedge clk); #1;
      if (Intr) begin
        k = i;
        break;
      end
    end
    cpu_mem_busy = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    checks++; if (state_dbg !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_en: got %b%b want 00", mem_en, mem_we); end
    checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin fails++; $display("FAIL reset_mem_bus: got %h %h want 0 0", mem_addr, mem_wdata); end
    checks++; if (Intr !== 1'b0) begin fails++; $display("FAIL reset_intr: got %b want 0", Intr); end
    checks++; if (DataOut !== 32'd0) begin fails++; $display("FAIL reset_dataout_idle: got %h want 0", DataOut); end
    for (int r = 0; r < 4; r++) begin
      read_reg(12'(r * 4), d);
      checks++; if (d !== 32'd0) begin fails++; $display("FAIL reset_reg%0d: got %h want 0", r, d); end
    end
  endtask

  task automatic test_basic;
    logic [31:0] d;
    int k, en0;
    for (int i = 0; i < 4; i++) preload(10'(64 + i), 32'hCAFE_0000 | 32'(i));
    for (int i = 0; i < 4; i++) preload(10'(128 + i), 32'd0);
    write_reg(12'h000, 32'h100);
    write_reg(12'h004, 32'h200);
    write_reg(12'h008, 32'd4);
    en0 = en_cnt;
    write_reg(12'h00C, 32'h3);
    wait_intr(1'b0, 100, k);
    checks++; if (k !== 13) begin fails++; $display("FAIL basic_latency: got %0d want 13", k); end
    read_reg(12'h00C, d);
    checks++; if (d !== 32'h6) begin fails++; $display("FAIL basic_stat: got %h want 6", d); end
    read_reg(12'h000, d);
    checks++; if (d !== 32'h100) begin fails++; $display("FAIL basic_src_kept: got %h want 100", d); end
    read_reg(12'h004, d);
    checks++; if (d !== 32'h200) begin fails++; $display("FAIL basic_dst_kept: got %h want 200", d); end
    read_reg(12'h008, d);
    checks++; if (d !== 32'd4) begin fails++; $display("FAIL basic_len_kept: got %h want 4", d); end
    checks++; if (en_cnt - en0 !== 8) begin fails++; $display("FAIL basic_en_count: got %0d want 8", en_cnt - en0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[128 + i] !== (32'hCAFE_0000 | 32'(i))) begin
        fails++; $display("FAIL basic_mem%0d: got %h want %h", i, mem[128 + i], 32'hCAFE_0000 | 32'(i));
      end
    end
    write_reg(12'h00C, 32'h4);
    checks++; if (Intr !== 1'b0) begin fails++; $display("FAIL basic_clear_intr: got %b want 0", Intr); end
    read_reg(12'h00C, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL basic_clear_stat: got %h want 0", d); end
  endtask

  task automatic test_contention;
    int k, v0;
    for (int i = 0; i < 4; i++) preload(10'(160 + i), 32'd0);
    write_reg(12'h004, 32'h280);
    v0 = busy_viol;
    write_reg(12'h00C, 32'h3);
    // Every RD/WR meets one busy cycle: 4 words x 1 stall on top of 13.
    wait_intr(1'b1, 100, k);
    checks++; if (k !== 17) begin fails++; $display("FAIL contend_latency: got %0d want 17", k); end
    checks++; if (busy_viol - v0 !== 0) begin fails++; $display("FAIL contend_en_while_busy: got %0d want 0", busy_viol - v0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[160 + i] !== (32'hCAFE_0000 | 32'(i))) begin
        fails++; $display("FAIL contend_mem%0d: got %h want %h", i, mem[160 + i], 32'hCAFE_0000 | 32'(i));
      end
    end
    write_reg(12'h00C, 32'h4);
  endtask

  task automatic test_len_zero;
    logic [31:0] d;
    int en0;
    write_reg(12'h008, 32'd0);
    en0 = en_cnt;
    write_reg(12'h00C, 32'h1);
    read_reg(12'h00C, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL len0_fin_stat: got %h want 0", d); end
    @(posedge clk); #1;
    read_reg(12'h00C, d);
    checks++; if (d !== 32'h4) begin fails++; $display("FAIL len0_done: got %h want 4", d); end
    checks++; if (Intr !== 1'b0) begin fails++; $display("FAIL len0_intr_masked: got %b want 0", Intr); end
    write_reg(12'h00C, 32'h4);
    write_reg(12'h00C, 32'h3);
    checks++; if (Intr !== 1'b0) begin fails++; $display("FAIL len0_intr_early: got %b want 0", Intr); end
    @(posedge clk); #1;
    checks++; if (Intr !== 1'b1) begin fails++; $display("FAIL len0_intr_ie: got %b want 1", Intr); end
    checks++; if (en_cnt - en0 !== 0) begin fails++; $display("FAIL len0_no_access: got %0d want 0", en_cnt - en0); end
    write_reg(12'h00C, 32'h4);
  endtask

  task automatic test_busy_writes;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) preload(10'(192 + i), 32'd0);
    write_reg(12'h000, 32'h100);
    write_reg(12'h004, 32'h300);
    write_reg(12'h008, 32'd4);
    write_reg(12'h00C, 32'h3);
    write_reg(12'h000, 32'hFFF);
    write_reg(12'h00C, 32'h3);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (state_dbg !== 3'd4) begin fails++; $display("FAIL busy_fin_state: got %0d want 4", state_dbg); end
    write_reg(12'h00C, 32'h6);
    read_reg(12'h00C, d);
    checks++; if (d !== 32'h6) begin fails++; $display("FAIL busy_done_set_wins: got %h want 6", d); end
    checks++; if (Intr !== 1'b1) begin fails++; $display("FAIL busy_intr: got %b want 1", Intr); end
    read_reg(12'h000, d);
    checks++; if (d !== 32'h100) begin fails++; $display("FAIL busy_src_ignored: got %h want 100", d); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[192 + i] !== (32'hCAFE_0000 | 32'(i))) begin
        fails++; $display("FAIL busy_mem%0d: got %h want %h", i, mem[192 + i], 32'hCAFE_0000 | 32'(i));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (state_dbg !== 3'd0) begin fails++; $display("FAIL busy_no_restart: got %0d want 0", state_dbg); end
    write_reg(12'h00C, 32'h4);
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    int k, q0;
    preload(10'd1023, 32'h1111_AAAA);
    preload(10'd0, 32'h2222_BBBB);
    preload(10'd256, 32'd0);
    preload(10'd257, 32'd0);
    write_reg(12'h000, 32'hFFFF_FFFC);
    write_reg(12'h004, 32'h400);
    write_reg(12'h008, 32'd2);
    q0 = rd_addr_q.size();
    write_reg(12'h00C, 32'h3);
    wait_intr(1'b0, 100, k);
    checks++; if (k !== 7) begin fails++; $display("FAIL wrap_latency: got %0d want 7", k); end
    checks++; if (rd_addr_q.size() - q0 !== 2) begin fails++; $display("FAIL wrap_read_count: got %0d want 2", rd_addr_q.size() - q0); end
    if (rd_addr_q.size() - q0 >= 2) begin
      checks++; if (rd_addr_q[q0] !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr0: got %h want fffffffc", rd_addr_q[q0]); end
      checks++; if (rd_addr_q[q0 + 1] !== 32'h0) begin fails++; $display("FAIL wrap_addr1: got %h want 0", rd_addr_q[q0 + 1]); end
    end
    checks++; if (mem[256] !== 32'h1111_AAAA) begin fails++; $display("FAIL wrap_mem0: got %h want 1111aaaa", mem[256]); end
    checks++; if (mem[257] !== 32'h2222_BBBB) begin fails++; $display("FAIL wrap_mem1: got %h want 2222bbbb", mem[257]); end
    write_reg(12'h00C, 32'h4);
    write_reg(12'h000, 32'h103);
    read_reg(12'h000, d);
    checks++; if (d !== 32'h100) begin fails++; $display("FAIL src_align: got %h want 100", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    preload(10'd224, 32'd0);
    write_reg(12'h000, 32'h100);
    write_reg(12'h004, 32'h380);
    write_reg(12'h008, 32'd4);
    write_reg(12'h00C, 32'h3);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (state_dbg !== 3'd3 || mem_we !== 1'b1) begin fails++; $display("FAIL mid_in_wr2: got %0d/%b want 3/1", state_dbg, mem_we); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (state_dbg !== 3'd0) begin fails++; $display("FAIL mid_state: got %0d want 0", state_dbg); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL mid_mem_en: got %b%b want 00", mem_en, mem_we); end
    checks++; if (Intr !== 1'b0) begin fails++; $display("FAIL mid_intr: got %b want 0", Intr); end
    checks++; if (DataOut !== 32'd0) begin fails++; $display("FAIL mid_dataout_idle: got %h want 0", DataOut); end
    for (int r = 0; r < 4; r++) begin
      read_reg(12'(r * 4), d);
      checks++; if (d !== 32'd0) begin fails++; $display("FAIL mid_reg%0d: got %h want 0", r, d); end
    end
    checks++; if (mem[224] !== 32'hCAFE_0000) begin fails++; $display("FAIL mid_partial: got %h want cafe0000", mem[224]); end
  endtask

  initial begin
    reset = 1'b1; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
    Addr = 12'd0; DataIn = 32'd0; cpu_mem_busy = 1'b0;
    mem_rdata = 32'd0; tb_we = 1'b0; tb_idx = 10'd0; tb_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_basic();
    test_contention();
    test_len_zero();
    test_busy_writes();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/dma_copy_ctrl.md
Name: dma_copy_ctrl

Overview:
- Memory-mapped DMA controller that copies a block of 32-bit words from one data-memory region to another.
- The CPU programs it through the same CS_N/RD_N/WR_N register interface used by the timer and GPIO peripherals; it gets its own chip select from the address decoder.
- It drives a secondary master port into the data-memory port and uses that port only in cycles where the CPU is not accessing data memory.
- On completion it raises a maskable interrupt.

Parameters:
- LEN_W, 16, width of the word-count register; maximum transfer is 2^LEN_W-1 words.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-high.
- CS_N  input  1  register-interface chip select, active-low.
- RD_N  input  1  register read strobe, active-low.
- WR_N  input  1  register write strobe, active-low.
- Addr  input  12  register byte offset.
- DataIn  input  32  register write data.
- DataOut  output  32  register read data.
- Intr  output  1  completion interrupt, level, active-high.
- cpu_mem_busy  input  1  high when the CPU is accessing data memory this cycle (inverted cs_mem_n).
- mem_en  output  1  DMA memory-port enable.
- mem_we  output  1  DMA memory-port write enable.
- mem_addr  output  32  DMA byte address; bits [1:0] are always 0.
- mem_wdata  output  32  DMA write data.
- mem_rdata  input  32  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Register map (Addr[3:0]; other bits ignored):
  - 0x0 SRC.
  - 0x4 DST.
  - 0x8 LEN (LEN_W bits, zero-extended on read).
  - 0xC CTRL/STAT:
    - write: bit0 START, bit1 IE, bit2 DONE write-1-to-clear.
    - read: bit0 BUSY, bit1 IE, bit2 DONE.
- Register writes take effect on the clk edge where CS_N=0 and WR_N=0.
- DataOut is combinational: the selected register when CS_N=0 and RD_N=0, otherwise 0.
- SRC and DST bits [1:0] are stored as 0.
- While BUSY, writes to SRC, DST and LEN are ignored, and START is ignored. IE and DONE-clear are always accepted.
- Reset values: SRC=DST=LEN=0, IE=0, DONE=0, state IDLE, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, Intr=0.
- Intr = DONE & IE, registered with the state.
- FSM states: IDLE, RD, CAP, WR, FIN.
  - IDLE: on START with LEN≠0, copy SRC, DST and LEN into working counters and go to RD, BUSY=1. On START with LEN=0, go to FIN with no memory access.
  - RD: if cpu_mem_busy=0, drive mem_en=1, mem_we=0, mem_addr=src_cnt, then go to CAP. Otherwise hold with mem_en=0.
  - CAP: latch mem_rdata into the word buffer and go to WR. Unconditional; the RAM holds data for one cycle.
  - WR: if cpu_mem_busy=0, drive mem_en=1, mem_we=1, mem_addr=dst_cnt, mem_wdata=buffer. Then add 4 to src_cnt and dst_cnt, decrement the word count, and go to FIN if the count reaches 0, otherwise RD. Otherwise hold with mem_en=0.
  - FIN: set DONE, BUSY=0, go to IDLE.
- Throughput is 3 cycles per word when uncontended. A transfer of N words with no contention takes 3N+1 cycles from the START write to DONE=1.
- mem_en/mem_we are combinational from state and cpu_mem_busy and must never be high in a cycle where cpu_mem_busy=1.
- Address counters wrap modulo 2^32. Overlapping regions are copied in ascending order with no overlap protection.
- If a DONE set (FIN) and a DONE write-1-clear occur in the same cycle, the set wins.
- Programmed SRC, DST and LEN registers are not modified by a transfer.
- Reset mid-transfer: the FSM returns to IDLE next edge, with mem_en=mem_we=0 and all registers at reset values. A partial copy is left in memory.

Test Plan:
- Program SRC=0x100, DST=0x200, LEN=4, CTRL=0x3, preload mem[0x100..0x10C]=A0..A3 -> mem[0x200..0x20C]=A0..A3, DONE=1 and Intr=1 after 13 cycles, BUSY=0, SRC still reads 0x100.
- Same transfer with cpu_mem_busy high on alternate cycles -> mem_en never asserted while cpu_mem_busy=1, final contents identical, completion delayed by exactly the number of stalled RD/WR cycles.
- LEN=0 with START -> no mem_en pulse, DONE=1 two cycles after the write, Intr follows IE.
- During BUSY, write SRC=0xFFF and START -> SRC still reads the old value, transfer unaffected. Write CTRL=0x4 in the FIN cycle -> DONE reads 1.
- SRC=0xFFFFFFFC, LEN=2 -> reads at 0xFFFFFFFC then 0x00000000 (wrap). Writing SRC=0x103 reads back 0x100.
- Assert reset during WR of word 2 of 4 -> next cycle state IDLE, mem_en=0, LEN/SRC/DST/DONE/IE=0, Intr=0, DataOut=0 with CS_N high.
